// File: rtl/mfp_display_pkg.sv
// Shared definitions for the multiplexed seven-segment display.
//   slot_state_e : per-slot FSM encoding (blank guard, then drive)
//   SegTable     : active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   SegBlank     : all segments off
package mfp_display_pkg;

    typedef enum logic {
        StBlank = 1'b0,
        StDrive = 1'b1
    } slot_state_e;

    localparam logic [6:0] SegBlank = 7'h7F;

    // Packed table, entry [n] is the pattern for hex value n (F listed first).
    localparam logic [15:0][6:0] SegTable = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage : mfp_display_pkg

// File: rtl/mfp_hex_to_seven_segment.sv
// Combinational hex-to-seven-segment decoder.
//   nibble_i   : hex value 0..F
//   segments_o : active-low {g,f,e,d,c,b,a}
module mfp_hex_to_seven_segment
    import mfp_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] segments_o
);

    assign segments_o = SegTable[nibble_i];

endmodule : mfp_hex_to_seven_segment

// File: rtl/mfp_seven_segment_scanner.sv
// Time-multiplexed scanner for a common-anode seven-segment display.
// Each digit gets a slot of 2^SCAN_DIV cycles; the first BLANK cycles of a slot
// keep everything dark to avoid ghosting. Inputs are captured once per frame.
//   clk_i        : system clock
//   resetn_i     : asynchronous active-low reset
//   number_i     : hex nibbles, nibble i drives digit i
//   digit_en_i   : per-digit enable
//   dot_i        : per-digit decimal point
//   brightness_i : PWM duty 0..15 (only with MFP_DISPLAY_BRIGHTNESS_EN)
//   anodes_o     : active-low digit selects (registered)
//   segments_o   : active-low {g,f,e,d,c,b,a} (registered)
//   dp_o         : active-low decimal point (registered)
// Optional feature macro: MFP_DISPLAY_BRIGHTNESS_EN
module mfp_seven_segment_scanner
    import mfp_display_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned BLANK    = 4
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [4*DIGITS-1:0]   number_i,
    input  logic [DIGITS-1:0]     digit_en_i,
    input  logic [DIGITS-1:0]     dot_i,
`ifdef MFP_DISPLAY_BRIGHTNESS_EN
    input  logic [3:0]            brightness_i,
`endif
    output logic [DIGITS-1:0]     anodes_o,
    output logic [6:0]            segments_o,
    output logic                  dp_o
);

    localparam int unsigned IdxW = $clog2(DIGITS);

    logic [SCAN_DIV-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    slot_state_e         state_q, state_d;

    logic [4*DIGITS-1:0] number_q;
    logic [DIGITS-1:0]   digit_en_q;
    logic [DIGITS-1:0]   dot_q;

    logic [DIGITS-1:0]   anodes_q, anodes_d;
    logic [6:0]          segments_q, segments_d;
    logic                dp_q, dp_d;

    logic                tick;
    logic                frame_wrap;
    logic [3:0]          nibble_sel;
    logic                en_sel;
    logic                dot_sel;
    logic [6:0]          seg_dec;
    logic [DIGITS-1:0]   anode_sel;
    logic                duty_on;

    assign tick       = &cnt_q;
    assign frame_wrap = tick && (idx_q == IdxW'(DIGITS - 1));

    // Counter, digit index and slot FSM next state.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        state_d = state_q;
        if (tick) begin
            idx_d = frame_wrap ? '0 : idx_q + 1'b1;
        end
        case (state_q)
            StBlank: if (cnt_q == SCAN_DIV'(BLANK - 1)) state_d = StDrive;
            StDrive: if (tick) state_d = StBlank;
            default: state_d = StBlank;
        endcase
    end

    // Per-digit select from the frame snapshot; loop keeps non-power-of-2
    // DIGITS from indexing past the vectors.
    always_comb begin
        nibble_sel = '0;
        en_sel     = 1'b0;
        dot_sel    = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                nibble_sel = number_q[4*i +: 4];
                en_sel     = digit_en_q[i];
                dot_sel    = dot_q[i];
            end
        end
    end

    assign anode_sel = ~(DIGITS'(1) << idx_q);

    mfp_hex_to_seven_segment u_hex_to_seven_segment (
        .nibble_i   (nibble_sel),
        .segments_o (seg_dec)
    );

`ifdef MFP_DISPLAY_BRIGHTNESS_EN
    logic [3:0] brightness_q;
    assign duty_on = (cnt_q[3:0] < brightness_q);
`else
    assign duty_on = 1'b1;
`endif

    // Output next state: dark by default, driven only in the DRIVE phase.
    always_comb begin
        anodes_d   = '1;
        segments_d = SegBlank;
        dp_d       = 1'b1;
        if (state_q == StDrive) begin
            if (en_sel && duty_on) anodes_d = anode_sel;
            segments_d = seg_dec;
            dp_d       = ~dot_sel;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            state_q    <= StBlank;
            anodes_q   <= '1;
            segments_q <= SegBlank;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            dp_q       <= dp_d;
        end
    end

    // Snapshot only at the frame boundary so a frame never mixes inputs.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            number_q   <= '0;
            digit_en_q <= '0;
            dot_q      <= '0;
        end else if (frame_wrap) begin
            number_q   <= number_i;
            digit_en_q <= digit_en_i;
            dot_q      <= dot_i;
        end
    end

`ifdef MFP_DISPLAY_BRIGHTNESS_EN
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            brightness_q <= '0;
        end else if (frame_wrap) begin
            brightness_q <= brightness_i;
        end
    end
`endif

    assign anodes_o   = anodes_q;
    assign segments_o = segments_q;
    assign dp_o       = dp_q;

endmodule : mfp_seven_segment_scanner

// File: doc/mfp_seven_segment_scanner.md
MFP_SEVEN_SEGMENT_SCANNER -- requirements
Module: mfp_seven_segment_scanner

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits, legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 16: digit slot length is 2^SCAN_DIV clk cycles, legal minimum 4.
REQ-003 Parameter BLANK, default 4: anti-ghost blank cycles at the start of each slot, 1 <= BLANK < 2^(SCAN_DIV-1).
REQ-004 clk  input  1  system clock; only clock domain of the block; all flops rise on posedge clk.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 number  input  4*DIGITS  hex nibbles; nibble i drives digit i.
REQ-007 digit_en  input  DIGITS  1 enables digit i; 0 blanks it.
REQ-008 dot  input  DIGITS  1 lights the decimal point of digit i.
REQ-009 anodes  output  DIGITS  active-low digit selects, registered.
REQ-010 segments  output  7  active-low {g,f,e,d,c,b,a}, registered.
REQ-011 dp  output  1  active-low decimal point, registered.

Function
REQ-012 Free-running SCAN_DIV-bit counter cnt shall increment every clk; wrap from all-ones to 0 is a slot tick.
REQ-013 Digit index idx shall advance by 1 on each tick, wrapping from DIGITS-1 to 0 (non-power-of-2 DIGITS shall skip no digit and show no phantom digit).
REQ-014 Slot FSM: state BLANK while cnt < BLANK, state DRIVE otherwise; BLANK->DRIVE when cnt == BLANK-1, DRIVE->BLANK on tick.
REQ-015 In BLANK, anodes shall be all ones, segments 7'h7F, and dp 1.
REQ-016 In DRIVE, anodes shall have only bit idx low, if snapshot digit_en[idx]=1; otherwise all ones.
REQ-017 In DRIVE, segments shall be the hex decode of the snapshot nibble idx: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-018 In DRIVE, dp shall be the inverse of snapshot dot[idx].
REQ-019 Outputs shall have exactly 1 clk latency from the cnt/idx/state value selecting them.
REQ-020 Snapshot registers for number, digit_en and dot shall load only on the tick where idx wraps DIGITS-1 -> 0, so one scan frame never mixes two input values.
REQ-021 Input changes at any other cycle shall have no effect until the next frame.

Reset
REQ-022 While resetn=0: cnt=0, idx=0, state BLANK, all snapshot bits 0, anodes all ones, segments 7'h7F, dp=1.
REQ-023 Reset asserted mid-slot shall blank all outputs immediately (asynchronously).
REQ-024 After release, the first frame displays nothing (snapshot digit_en=0); the first loaded frame starts at cycle DIGITS*2^SCAN_DIV.

Configuration
REQ-025 Macro MFP_DISPLAY_BRIGHTNESS_EN defined: add input brightness [3:0]; in DRIVE, the anode shall be low only when cnt[3:0] < brightness, otherwise all ones; brightness=0 gives a fully dark display, 15 gives a 15/16 duty.
REQ-026 brightness shall be snapshotted with the other inputs per REQ-020.
REQ-027 Macro undefined: the port is absent and the anode shall be low for the whole DRIVE phase.

Structure
REQ-028 The 16-entry segment constant table and the FSM state encoding (BLANK, DRIVE) shall live in the shared package mfp_display_pkg.
REQ-029 Hex decode shall be one combinational sub-module, mfp_hex_to_seven_segment, instantiated once in the scanner.
REQ-030 The scanner shall contain no other sub-modules.

Verification (DIGITS=8, SCAN_DIV=4, BLANK=2)
REQ-031 Reset release, number=32'h76543210, digit_en=8'hFF -> anodes all ones for 128 cycles, then slot 0 shows anodes=8'hFE, segments=7'h40 from cnt=2 (+1 latency).
REQ-032 Steady frame -> anodes cycle FE,FD,FB,...,7F with 16-cycle slots, cycles with cnt=0..1 all ones, digit 7 segments=7'h78.
REQ-033 Change number to 32'hFFFFFFFF mid-frame at digit 3 -> digits 3..7 still show 3..7; next frame shows 7'h0E on all digits.
REQ-034 digit_en=8'h0F, dot=8'h01 -> anodes stay all ones in slots 4..7; dp=0 only in slot 0 DRIVE.
REQ-035 Assert resetn=0 mid-DRIVE of slot 5 -> outputs all ones in the same cycle; idx restarts at 0 after release.
REQ-036 With MFP_DISPLAY_BRIGHTNESS_EN, brightness=4'd8 -> in each slot the anode is low for cnt=2..7 only; brightness=0 -> anodes always all ones.
